wb_stage_pipe: RTL

Parametrised write-back stage for the RV32I pipeline. It replaces the purely combinational result-select mux with a registered stage that:
- accepts MEM-stage results over a valid/ready handshake;
- waits for multi-cycle data-memory load responses;
- aligns and sign/zero-extends sub-word loads;
- drives the register-file write port one cycle later.

It also keeps a retired-instruction counter and flags misaligned or illegal loads.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_stage_pipe_load_align.sv | 52 +++++
 rtl/wb_stage_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the RV32I write-back stage.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        DRAIN     = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Byte-lane selection and sign/zero extension of a raw load word.
// Misaligned or illegal loads raise err_c and force the data to zero.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] load_word_i,
    output logic [XLEN-1:0] data_c,
    output logic            err_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = load_word_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = load_word_i[15:8];
            2'd2:    byte_sel = load_word_i[23:16];
            2'd3:    byte_sel = load_word_i[31:24];
            default: byte_sel = load_word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

        data_c = '0;
        err_c  = 1'b0;
        case (funct3_i)
            F3_LB:  data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH: begin
                err_c  = addr_lo_i[0];
                data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            F3_LW: begin
                err_c  = (addr_lo_i != 2'd0);
                data_c = load_word_i;
            end
            F3_LBU: data_c = XLEN'(byte_sel);
            F3_LHU: begin
                err_c  = addr_lo_i[0];
                data_c = XLEN'(half_sel);
            end
            default: err_c = 1'b1;
        endcase
        if (err_c) begin
            data_c = '0;
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: result select, multi-cycle load wait,
// load alignment, register-file write port and retired-instruction counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        wb_sel,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   next_pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              load_rsp_valid,
    input  logic [XLEN-1:0]   load_word,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              load_err,
    output logic [CNT_W-1:0]  instret,
    output logic              busy
);

    wb_state_e         state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              load_err_q, load_err_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic              pend_we_q, pend_we_d;
    logic [2:0]        pend_f3_q, pend_f3_d;
    logic [1:0]        pend_lo_q, pend_lo_d;

    logic              accept;
    logic              retire;
    logic [REG_AW-1:0] ret_rd;
    logic              ret_we;
    logic [XLEN-1:0]   ret_data;
    logic              ret_err;
    logic [2:0]        al_f3;
    logic [1:0]        al_lo;
    logic [XLEN-1:0]   al_data;
    logic              al_err;

    // A waiting load extracts with the fields captured at accept time.
    assign al_f3  = (state_q == WAIT_LOAD) ? pend_f3_q : funct3;
    assign al_lo  = (state_q == WAIT_LOAD) ? pend_lo_q : addr_lo;
    assign accept = in_ready_q & in_valid & ~flush;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i    (al_f3),
        .addr_lo_i   (al_lo),
        .load_word_i (load_word),
        .data_c      (al_data),
        .err_c       (al_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        pend_we_d = pend_we_q;
        pend_f3_d = pend_f3_q;
        pend_lo_d = pend_lo_q;
        retire    = 1'b0;
        ret_rd    = rd_addr;
        ret_we    = reg_write;
        ret_data  = alu_out;
        ret_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wb_sel != WB_SEL_LOAD) begin
                        retire = 1'b1;
                        case (wb_sel)
                            WB_SEL_PC4: ret_data = next_pc;
                            WB_SEL_IMM: ret_data = imm;
                            default:    ret_data = alu_out;
                        endcase
                    end else if (load_rsp_valid) begin
                        retire   = 1'b1;
                        ret_data = al_data;
                        ret_err  = al_err;
                    end else begin
                        state_d   = WAIT_LOAD;
                        pend_rd_d = rd_addr;
                        pend_we_d = reg_write;
                        pend_f3_d = funct3;
                        pend_lo_d = addr_lo;
                    end
                end
            end
            WAIT_LOAD: begin
                ret_rd = pend_rd_q;
                ret_we = pend_we_q;
                if (flush) begin
                    state_d = load_rsp_valid ? IDLE : DRAIN;
                end else if (load_rsp_valid) begin
                    retire   = 1'b1;
                    ret_data = al_data;
                    ret_err  = al_err;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (load_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rf_we_d    = retire & ret_we & (ret_rd != '0) & ~ret_err;
        rf_waddr_d = retire ? ret_rd : rf_waddr_q;
        rf_wdata_d = retire ? ret_data : rf_wdata_q;
        load_err_d = retire & ret_err;
        instret_d  = instret_q + CNT_W'(retire);
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            load_err_q <= 1'b0;
            instret_q  <= '0;
            pend_rd_q  <= '0;
            pend_we_q  <= 1'b0;
            pend_f3_q  <= '0;
            pend_lo_q  <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            load_err_q <= load_err_d;
            instret_q  <= instret_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            pend_f3_q  <= pend_f3_d;
            pend_lo_q  <= pend_lo_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign load_err = load_err_q;
    assign instret  = instret_q;

endmodule
